sseg_scan_capture: RTL and testbench

- Receiving end of the multiplexed 8-digit 7-segment interface: monitors `anode`/`sseg` pin pairs driven by a scanning display driver.
- Reconstructs the hex value, decimal point and blank/valid status of each of the 8 digits.
- Used on a second board, or in self-check logic, to read back counter values shown on the display; sits directly behind the pins.

---
 rtl/sseg_scan_capture_pkg.sv | 43 ++++
 rtl/sseg_glyph_decode.sv | 43 ++++
 rtl/sseg_scan_capture.sv | 221 ++++++++++++++++++++++
 tb/tb_sseg_scan_capture.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_scan_capture_pkg.sv
// Shared definitions for the 7-segment scan capture block.
// Holds the active-low glyph patterns, which the display driver's encoder
// also uses, so both ends agree on every segment map. Also holds the digit
// geometry, the capture FSM state type and a one-hot-low test.
package sseg_scan_capture_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int NIBBLE_W   = 4;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // True when exactly one anode line is pulled low
  function automatic logic is_onehot_low(input logic [NUM_DIGITS-1:0] an);
    logic [NUM_DIGITS-1:0] act;
    act = ~an;
    return (act != {NUM_DIGITS{1'b0}}) &&
           ((act & (act - NUM_DIGITS'(1))) == {NUM_DIGITS{1'b0}});
  endfunction

endpackage

// File: rtl/sseg_glyph_decode.sv
// Combinational decoder: active-low 7-segment pattern -> hex code.
// Ports:
//   pattern  in  7  segment lines g..a, active-low
//   legal    out 1  pattern is a known glyph or the all-off blank
//   blank    out 1  pattern is all segments off
//   code     out 4  hex value (0 for blank or unknown patterns)
module sseg_glyph_decode
  import sseg_scan_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic       blank,
  output logic [3:0] code
);

  // Pattern lookup; anything not in the glyph set is flagged illegal
  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    code  = 4'h0;
    case (pattern)
      SEG_0:     code = 4'h0;
      SEG_1:     code = 4'h1;
      SEG_2:     code = 4'h2;
      SEG_3:     code = 4'h3;
      SEG_4:     code = 4'h4;
      SEG_5:     code = 4'h5;
      SEG_6:     code = 4'h6;
      SEG_7:     code = 4'h7;
      SEG_8:     code = 4'h8;
      SEG_9:     code = 4'h9;
      SEG_A:     code = 4'hA;
      SEG_B:     code = 4'hB;
      SEG_C:     code = 4'hC;
      SEG_D:     code = 4'hD;
      SEG_E:     code = 4'hE;
      SEG_F:     code = 4'hF;
      SEG_BLANK: blank = 1'b1;
      default:   legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/sseg_scan_capture.sv
// Receiver for a multiplexed 8-digit active-low 7-segment display bus.
// Rebuilds each digit's hex value, decimal point, blank and valid status
// from the scanned anode/sseg pins.
// Ports:
//   ckht        in  1   system clock
//   rst         in  1   asynchronous active-low reset
//   anode       in  8   digit enables, active-low (bit i = digit i)
//   sseg        in  8   segments, active-low; bit7 = dp, 6:0 = g..a
//   digits      out 32  captured hex codes, digit i at [4i+3:4i]
//   dp          out 8   captured decimal points, active-high
//   dig_vld     out 8   digit holds a recognised glyph refreshed recently
//   blank       out 8   digit last captured with all segments off
//   frame_done  out 1   pulse once every position has been captured
//   err_cnt     out 8   saturating error count
// Optional feature macro: SSEG_SCAN_ERR_EN enables err_cnt (else tied 0).
module sseg_scan_capture
  import sseg_scan_capture_pkg::*;
#(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        ckht,
  input  logic        rst,
  input  logic [7:0]  anode,
  input  logic [7:0]  sseg,
  output logic [31:0] digits,
  output logic [7:0]  dp,
  output logic [7:0]  dig_vld,
  output logic [7:0]  blank,
  output logic        frame_done,
  output logic [7:0]  err_cnt
);

  localparam int CNT_W = $clog2(STABLE_CYC + 1);
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] STABLE_M1 = CNT_W'(STABLE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(TIMEOUT_CYC - 1);

  logic [15:0] sync1_r, sync2_r, prev_r;
  logic [7:0]  s_anode_s, s_sseg_s;
  logic        same_s, onehot_s, cap_s;
  logic [IDX_W-1:0] cap_idx_s;
  logic        dec_legal_s, dec_blank_s;
  logic [3:0]  dec_code_s;

  scan_state_e           state_r;
  logic [CNT_W-1:0]      cnt_r;
  logic [NUM_DIGITS-1:0][NIBBLE_W-1:0] digits_r;
  logic [7:0]            dp_r, vld_r, blank_r, seen_r;
  logic                  frame_done_r;
  logic [TMO_W-1:0]      tmo_r [NUM_DIGITS];
  logic                  seen_full_s;

  assign s_anode_s = sync2_r[15:8];
  assign s_sseg_s  = sync2_r[7:0];
  assign same_s    = (sync2_r == prev_r);
  assign onehot_s  = is_onehot_low(s_anode_s);

  // Two-stage synchronizer plus the previous-sample register
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      sync1_r <= 16'hFFFF;
      sync2_r <= 16'hFFFF;
      prev_r  <= 16'hFFFF;
    end else begin
      sync1_r <= {anode, sseg};
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  sseg_glyph_decode u_decode (
    .pattern (s_sseg_s[6:0]),
    .legal   (dec_legal_s),
    .blank   (dec_blank_s),
    .code    (dec_code_s)
  );

  // Capture fires on the sample that completes the stable run; the index is
  // the low anode bit (only meaningful while the anode is one-hot-low)
  always_comb begin
    cap_idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      cap_idx_s = s_anode_s[i] ? cap_idx_s : IDX_W'(i);
    end
    if ((state_r == ST_SETTLE) && same_s && (cnt_r == STABLE_M1)) begin
      cap_s = 1'b1;
    end else begin
      cap_s = 1'b0;
    end
  end

  // Settle FSM: count consecutive identical one-hot samples
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (onehot_s) begin
            state_r <= ST_SETTLE;
            cnt_r   <= CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (same_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == STABLE_M1) state_r <= ST_HOLD;
          end else if (onehot_s) begin
            cnt_r <= CNT_W'(1);
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // Any change restarts exactly as IDLE would on the new sample
          if (!same_s) begin
            state_r <= onehot_s ? ST_SETTLE : ST_IDLE;
            cnt_r   <= CNT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  // Per-digit capture registers and refresh timeout
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      digits_r <= '0;
      dp_r     <= 8'h00;
      vld_r    <= 8'h00;
      blank_r  <= 8'h00;
      for (int i = 0; i < NUM_DIGITS; i++) tmo_r[i] <= {TMO_W{1'b0}};
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap_s && (cap_idx_s == IDX_W'(i))) begin
          dp_r[i]  <= ~s_sseg_s[7];
          tmo_r[i] <= {TMO_W{1'b0}};
          if (dec_legal_s) begin
            digits_r[i] <= dec_code_s;
            blank_r[i]  <= dec_blank_s;
            vld_r[i]    <= 1'b1;
          end else begin
            vld_r[i] <= 1'b0;
          end
        end else if (tmo_r[i] == TMO_MAX) begin
          vld_r[i] <= 1'b0;
        end else begin
          tmo_r[i] <= tmo_r[i] + TMO_W'(1);
        end
      end
    end
  end

  assign seen_full_s = (seen_r == 8'hFF);

  // Frame tracking: pulse and clear one cycle after the mask fills; a
  // capture on the clearing cycle lands in the fresh mask
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      seen_r       <= 8'h00;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= seen_full_s;
      seen_r <= (seen_full_s ? 8'h00 : seen_r) |
                (cap_s ? (8'h01 << cap_idx_s) : 8'h00);
    end
  end

`ifdef SSEG_SCAN_ERR_EN
  logic [CNT_W-1:0] mh_cnt_r;
  logic [7:0]       err_cnt_r;
  logic             multi_s, an_same_s, mh_evt_s, err_evt_s;

  // A multi-hot anode is judged on the anode lines alone
  assign multi_s   = (s_anode_s != 8'hFF) && !onehot_s;
  assign an_same_s = (s_anode_s == prev_r[15:8]);
  assign mh_evt_s  = multi_s && an_same_s && (mh_cnt_r == STABLE_M1);
  assign err_evt_s = (cap_s && !dec_legal_s) || mh_evt_s;

  // Stable-run counter for multi-hot anodes; stops at STABLE_CYC so each
  // occurrence is reported once
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      mh_cnt_r <= {CNT_W{1'b0}};
    end else if (!multi_s) begin
      mh_cnt_r <= {CNT_W{1'b0}};
    end else if (!an_same_s) begin
      mh_cnt_r <= CNT_W'(1);
    end else if (mh_cnt_r != CNT_W'(STABLE_CYC)) begin
      mh_cnt_r <= mh_cnt_r + CNT_W'(1);
    end
  end

  // Saturating error counter
  always_ff @(posedge ckht or negedge rst) begin
    if (!rst) begin
      err_cnt_r <= 8'h00;
    end else if (err_evt_s && (err_cnt_r != 8'hFF)) begin
      err_cnt_r <= err_cnt_r + 8'h01;
    end
  end

  assign err_cnt = err_cnt_r;
`else
  assign err_cnt = 8'h00;
`endif

  assign digits     = digits_r;
  assign dp         = dp_r;
  assign dig_vld    = vld_r;
  assign blank      = blank_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_sseg_scan_capture.sv
module tb_sseg_scan_capture;

  localparam int STABLE  = 16;
  localparam int TIMEOUT = 1000;
  localparam int LAT     = STABLE + 2;

  logic        ckht, rst;
  logic [7:0]  anode, sseg;
  logic [31:0] digits;
  logic [7:0]  dp, dig_vld, blank, err_cnt;
  logic        frame_done;

  int total, bad, cyc, fd_cnt;

  logic [6:0] glyph [16];

  sseg_scan_capture #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TIMEOUT)) dut (
    .ckht(ckht), .rst(rst), .anode(anode), .sseg(sseg),
    .digits(digits), .dp(dp), .dig_vld(dig_vld), .blank(blank),
    .frame_done(frame_done), .err_cnt(err_cnt)
  );

  initial begin
    ckht = 1'b0;
    forever #5 ckht = ~ckht;
  end

  // one clock edge; outputs sampled 1 ns later
  task automatic tick();
    @(posedge ckht);
    cyc++;
    #1;
    if (frame_done === 1'b1) fd_cnt++;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] s);
    anode = a;
    sseg  = s;
  endtask

  task automatic do_reset();
    drive(8'hFF, 8'hFF);
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    fd_cnt = 0;
  endtask

  // spec glyph table: 0..15 value, 16 blank, -1 unknown
  function automatic int glyph_val(input logic [6:0] p);
    if (p == 7'h7F) return 16;
    for (int g = 0; g < 16; g++) if (glyph[g] == p) return g;
    return -1;
  endfunction

  function automatic logic [7:0] exp_err(input int n);
`ifdef SSEG_SCAN_ERR_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return 8'h00;
`endif
  endfunction

  task automatic test_reset();
    do_reset();
    total++;
    if (digits !== 32'h0 || dp !== 8'h00 || dig_vld !== 8'h00 || blank !== 8'h00 ||
        frame_done !== 1'b0 || err_cnt !== 8'h00) begin
      bad++;
      $display("FAIL reset_state digits=%h dp=%h vld=%h blank=%h fd=%b err=%h expected all 0",
               digits, dp, dig_vld, blank, frame_done, err_cnt);
    end
    // capture something, then reset in the middle of a new settle
    drive(8'hFE, 8'h92);
    repeat (24) tick();
    drive(8'hFD, 8'hF9);
    repeat (10) tick();
    #2 rst = 1'b0;
    #1;
    total++;
    if (digits !== 32'h0 || dig_vld !== 8'h00 || dp !== 8'h00) begin
      bad++;
      $display("FAIL reset_async digits=%h vld=%h dp=%h expected 0", digits, dig_vld, dp);
    end
    tick();
    rst = 1'b1;
    for (int k = 1; k <= LAT + 2; k++) begin
      tick();
      if (k == LAT - 1) begin
        total++;
        if (dig_vld !== 8'h00) begin
          bad++;
          $display("FAIL reset_no_early vld=%h expected 00", dig_vld);
        end
      end
      if (k == LAT) begin
        total++;
        if (dig_vld !== 8'h02 || digits !== 32'h10) begin
          bad++;
          $display("FAIL reset_recapture vld=%h digits=%h expected 02 00000010", dig_vld, digits);
        end
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(8'hFE, 8'h92);
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == LAT - 1) begin
        total++;
        if (dig_vld !== 8'h00 || digits !== 32'h0) begin
          bad++;
          $display("FAIL single_early vld=%h digits=%h expected 00 0", dig_vld, digits);
        end
      end
      if (k >= LAT) begin
        total++;
        if (digits !== 32'h5 || dig_vld !== 8'h01 || dp !== 8'h00 || blank !== 8'h00) begin
          bad++;
          $display("FAIL single_capture k=%0d digits=%h vld=%h dp=%h blank=%h expected 5 01 00 00",
                   k, digits, dig_vld, dp, blank);
        end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    drive(8'hFE, 8'h92);
    repeat (10) tick();
    drive(8'hFF, 8'hFF);
    repeat (30) tick();
    total++;
    if (digits !== 32'h0 || dig_vld !== 8'h00 || dp !== 8'h00) begin
      bad++;
      $display("FAIL glitch digits=%h vld=%h dp=%h expected 0", digits, dig_vld, dp);
    end
  endtask

  task automatic scan_frame(output int cap [8]);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] a;
      a = ~(8'h01 << i);
      drive(a, {1'b1, glyph[i]});
      cap[i] = cyc + LAT;
      repeat (32) tick();
    end
    drive(8'hFF, 8'hFF);
  endtask

  task automatic test_scan();
    int cap [8];
    do_reset();
    scan_frame(cap);
    repeat (20) tick();
    total++;
    if (digits !== 32'h76543210 || dig_vld !== 8'hFF || dp !== 8'h00 || blank !== 8'h00) begin
      bad++;
      $display("FAIL scan_values digits=%h vld=%h dp=%h blank=%h expected 76543210 FF 00 00",
               digits, dig_vld, dp, blank);
    end
    total++;
    if (fd_cnt != 1) begin
      bad++;
      $display("FAIL scan_frame_done pulses=%0d expected 1", fd_cnt);
    end
  endtask

  task automatic test_errors();
    do_reset();
    drive(8'hFC, 8'hFF);
    repeat (40) tick();
    drive(8'hFD, 8'h55);
    repeat (40) tick();
    drive(8'hFF, 8'hFF);
    repeat (20) tick();
    total++;
    if (err_cnt !== exp_err(2)) begin
      bad++;
      $display("FAIL err_count err_cnt=%h expected %h", err_cnt, exp_err(2));
    end
    total++;
    if (dig_vld !== 8'h00 || dp !== 8'h02 || digits !== 32'h0) begin
      bad++;
      $display("FAIL err_digit vld=%h dp=%h digits=%h expected 00 02 0", dig_vld, dp, digits);
    end
  endtask

  task automatic test_timeout();
    int cap [8];
    do_reset();
    scan_frame(cap);
    while (cyc <= cap[7] + TIMEOUT + 1) begin
      tick();
      for (int i = 0; i < 8; i++) begin
        if (cyc == cap[i] + TIMEOUT - 1) begin
          total++;
          if (dig_vld[i] !== 1'b1) begin
            bad++;
            $display("FAIL timeout_hold pos=%0d vld=%b expected 1", i, dig_vld[i]);
          end
        end
        if (cyc == cap[i] + TIMEOUT) begin
          total++;
          if (dig_vld[i] !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear pos=%0d vld=%b expected 0", i, dig_vld[i]);
          end
        end
      end
    end
    total++;
    if (dig_vld !== 8'h00 || digits !== 32'h76543210) begin
      bad++;
      $display("FAIL timeout_retain vld=%h digits=%h expected 00 76543210", dig_vld, digits);
    end
  endtask

  task automatic test_random();
    logic [3:0]  m_dig [8];
    logic [7:0]  m_vld, m_dp, m_blank, m_seen, ev_vld;
    logic [31:0] ev_dig;
    int          m_cap [8];
    int          m_err, m_fd, len, r, gv;
    logic [7:0]  a, s, pa, ps;
    do_reset();
    for (int i = 0; i < 8; i++) begin m_dig[i] = 4'h0; m_cap[i] = 0; end
    m_vld = 8'h00; m_dp = 8'h00; m_blank = 8'h00; m_seen = 8'h00;
    m_err = 0; m_fd = 0;
    pa = 8'hFF; ps = 8'hFF;
    for (int seg = 0; seg < 40; seg++) begin
      int tries;
      tries = 0;
      do begin
        r = int'($urandom_range(0, 19));
        if (r < 14) a = ~(8'h01 << $urandom_range(0, 7));
        else if (r < 17) a = 8'hFF;
        else begin
          a = 8'($urandom);
          while ($countones(~a) < 2 || a == pa) a = 8'($urandom);
        end
        r = int'($urandom_range(0, 19));
        if (r < 16) s[6:0] = glyph[r];
        else if (r < 18) s[6:0] = 7'h7F;
        else s[6:0] = 7'($urandom);
        s[7] = 1'($urandom);
        tries++;
      end while ({a, s} == {pa, ps} && tries < 50);
      len = int'($urandom_range(2, 34));
      if (len >= STABLE) begin
        if ($countones(~a) == 1) begin
          int p;
          p = 0;
          for (int i = 0; i < 8; i++) if (!a[i]) p = i;
          gv = glyph_val(s[6:0]);
          m_dp[p] = ~s[7];
          m_cap[p] = cyc + LAT;
          if (gv < 0) begin
            m_vld[p] = 1'b0;
            m_err++;
          end else begin
            m_vld[p] = 1'b1;
            m_blank[p] = (gv == 16);
            m_dig[p] = (gv == 16) ? 4'h0 : 4'(gv);
          end
          m_seen[p] = 1'b1;
          if (m_seen == 8'hFF) begin
            m_fd++;
            m_seen = 8'h00;
          end
        end else if (a != 8'hFF) begin
          m_err++;
        end
      end
      drive(a, s);
      pa = a; ps = s;
      repeat (len) tick();
    end
    drive(8'hFF, 8'hFF);
    repeat (LAT + 4) tick();
    for (int i = 0; i < 8; i++) begin
      ev_dig[4*i +: 4] = m_dig[i];
      ev_vld[i] = m_vld[i] && ((cyc - m_cap[i]) < TIMEOUT);
    end
    total++;
    if (digits !== ev_dig) begin
      bad++;
      $display("FAIL rand_digits got=%h expected=%h", digits, ev_dig);
    end
    total++;
    if (dig_vld !== ev_vld) begin
      bad++;
      $display("FAIL rand_vld got=%h expected=%h", dig_vld, ev_vld);
    end
    total++;
    if (dp !== m_dp || blank !== m_blank) begin
      bad++;
      $display("FAIL rand_dp_blank dp=%h blank=%h expected %h %h", dp, blank, m_dp, m_blank);
    end
    total++;
    if (err_cnt !== exp_err(m_err)) begin
      bad++;
      $display("FAIL rand_err got=%h expected=%h", err_cnt, exp_err(m_err));
    end
    total++;
    if (fd_cnt != m_fd) begin
      bad++;
      $display("FAIL rand_frames got=%0d expected=%0d", fd_cnt, m_fd);
    end
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    total = 0; bad = 0; cyc = 0; fd_cnt = 0;
    rst = 1'b0;
    anode = 8'hFF;
    sseg  = 8'hFF;
    test_reset();
    test_single();
    test_glitch();
    test_scan();
    test_errors();
    test_timeout();
    test_random();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
